// File: rtl/joy_serial_scanner.sv
// Serial front end for the two DB9 joystick ports: drives JOY_CLK/JOY_LOAD and shifts in 16 bits per frame.
// Optional macro JOY_DEBOUNCE_EN: outputs update only when two consecutive frames agree.
module joy_serial_scanner #(
  parameter int CLKDIV    = 50,
  parameter int GAP_TICKS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clock_locked,
  input  logic       joy_data,
  output logic       joy_clk,
  output logic       joy_load,
  output logic [5:0] joy1,
  output logic [5:0] joy2,
  output logic       frame_strobe
);

  localparam int CNT_W = $clog2(CLKDIV);
  localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(CLKDIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_TICKS - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LOAD     = 3'd1;
  localparam logic [2:0] SHIFT_LO = 3'd2;
  localparam logic [2:0] SHIFT_HI = 3'd3;
  localparam logic [2:0] LATCH    = 3'd4;
  localparam logic [2:0] GAP      = 3'd5;

  logic [2:0]       state_r;
  logic [CNT_W-1:0] tick_cnt_r;
  logic [GAP_W-1:0] gap_cnt_r;
  logic [3:0]       idx_r;
  // Only the 12 used frame bits are stored: slots 0-5 hold joy1, slots 6-11 hold joy2.
  logic [11:0]      sh_r;
  logic             tick_s;
  logic             keep_s;
  logic [3:0]       slot_s;
`ifdef JOY_DEBOUNCE_EN
  logic [11:0]      prev_r;
`endif

  // Tick strobe and mapping of shift index to stored slot (bits 6,7,14,15 are dropped).
  always_comb begin
    tick_s = (tick_cnt_r == TICK_LAST);
    keep_s = (idx_r[2:1] != 2'b11);
    if (idx_r[3]) begin
      slot_s = {1'b0, idx_r[2:0]} + 4'd6;
    end else begin
      slot_s = {1'b0, idx_r[2:0]};
    end
  end

  // Scan tick divider, parked at zero whenever the scanner is idle or unlocked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_r <= '0;
    end else if (!clock_locked || (state_r == IDLE) || tick_s) begin
      tick_cnt_r <= '0;
    end else begin
      tick_cnt_r <= tick_cnt_r + CNT_W'(1);
    end
  end

  // Frame sequencer with registered pin drives, capture and output latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      idx_r        <= 4'd0;
      gap_cnt_r    <= '0;
      sh_r         <= '1;
      joy_clk      <= 1'b0;
      joy_load     <= 1'b1;
      joy1         <= 6'h3F;
      joy2         <= 6'h3F;
      frame_strobe <= 1'b0;
`ifdef JOY_DEBOUNCE_EN
      prev_r       <= '1;
`endif
    end else begin
      frame_strobe <= 1'b0;
      if (!clock_locked) begin
        // Lock loss abandons the partial frame; joy1/joy2 keep their last values.
        state_r   <= IDLE;
        idx_r     <= 4'd0;
        gap_cnt_r <= '0;
        sh_r      <= '1;
        joy_clk   <= 1'b0;
        joy_load  <= 1'b1;
      end else begin
        case (state_r)
          IDLE: begin
            state_r  <= LOAD;
            idx_r    <= 4'd0;
            joy_load <= 1'b0;
            joy_clk  <= 1'b0;
          end
          LOAD: begin
            if (tick_s) begin
              joy_load <= 1'b1;
              idx_r    <= 4'd0;
              state_r  <= SHIFT_LO;
            end
          end
          SHIFT_LO: begin
            if (tick_s) begin
              if (keep_s) begin
                sh_r[slot_s] <= joy_data;
              end
              joy_clk <= 1'b1;
              state_r <= SHIFT_HI;
            end
          end
          SHIFT_HI: begin
            if (tick_s) begin
              joy_clk <= 1'b0;
              if (idx_r == 4'd15) begin
                state_r <= LATCH;
              end else begin
                idx_r   <= idx_r + 4'd1;
                state_r <= SHIFT_LO;
              end
            end
          end
          LATCH: begin
            if (tick_s) begin
`ifdef JOY_DEBOUNCE_EN
              if (sh_r == prev_r) begin
                joy1 <= sh_r[5:0];
                joy2 <= sh_r[11:6];
              end
              prev_r <= sh_r;
`else
              joy1 <= sh_r[5:0];
              joy2 <= sh_r[11:6];
`endif
              frame_strobe <= 1'b1;
              gap_cnt_r    <= '0;
              state_r      <= GAP;
            end
          end
          GAP: begin
            if (tick_s) begin
              if (gap_cnt_r == GAP_LAST) begin
                joy_load <= 1'b0;
                state_r  <= LOAD;
              end else begin
                gap_cnt_r <= gap_cnt_r + GAP_W'(1);
              end
            end
          end
          default: begin
            state_r  <= IDLE;
            joy_clk  <= 1'b0;
            joy_load <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_joy_serial_scanner.sv
// Self-checking bench for joy_serial_scanner: table of per-frame patterns plus lock-loss and reset sequences.
// Expectations follow the JOY_DEBOUNCE_EN setting of the build.
module tb_joy_serial_scanner;

  localparam int CLKDIV  = 4;
  localparam int GAP     = 2;
  localparam int PERIOD  = (34 + GAP) * CLKDIV;
  localparam int LATENCY = 34 * CLKDIV + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clock_locked = 1'b0;
  logic       joy_data;
  logic       joy_clk, joy_load, frame_strobe;
  logic [5:0] joy1, joy2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_cyc = 0;
  int n;
  int viol;

  logic [15:0] pattern = 16'hFFFF;
  logic [15:0] chain = 16'hFFFF;
  logic        jclk_d = 1'b0;

  typedef struct {
    logic [15:0] pat;
    logic [5:0]  j1, j2, j1_db, j2_db;
  } vec_t;
  vec_t vecs[12];

  joy_serial_scanner #(.CLKDIV(CLKDIV), .GAP_TICKS(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .clock_locked(clock_locked), .joy_data(joy_data),
    .joy_clk(joy_clk), .joy_load(joy_load), .joy1(joy1), .joy2(joy2),
    .frame_strobe(frame_strobe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shift-register chain model: parallel load while joy_load is low, shift after each joy_clk rise.
  always @(posedge clk) begin
    jclk_d <= joy_clk;
    if (!joy_load) chain <= pattern;
    else if (joy_clk && !jclk_d) chain <= {1'b1, chain[15:1]};
  end
  assign joy_data = chain[0];

  function automatic logic [5:0] pick(input logic [5:0] plain, input logic [5:0] debounced);
`ifdef JOY_DEBOUNCE_EN
    return debounced;
`else
    return plain;
`endif
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic wait_strobe(input int limit, output int waited);
    waited = 0;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (!frame_strobe && waited < limit);
    if (!frame_strobe) begin
      checks++;
      failures++;
      $display("FAIL strobe_timeout: no strobe after %0d cycles", waited);
    end
  endtask

  task automatic wait_edges(input logic rising, input int count);
    int   seen = 0;
    int   waited = 0;
    logic prev = joy_clk;
    while (seen < count && waited < 400) begin
      @(posedge clk); #1;
      waited++;
      if (rising ? (joy_clk && !prev) : (!joy_clk && prev)) seen++;
      prev = joy_clk;
    end
    if (seen < count) begin
      checks++;
      failures++;
      $display("FAIL joy_clk_edges: saw %0d of %0d edges", seen, count);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_joy_clk"}, 16'(joy_clk), 16'h0);
    chk({tag, "_joy_load"}, 16'(joy_load), 16'h1);
    chk({tag, "_joy1"}, 16'(joy1), 16'h3F);
    chk({tag, "_joy2"}, 16'(joy2), 16'h3F);
    chk({tag, "_strobe"}, 16'(frame_strobe), 16'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{16'hFFFE, 6'h3E, 6'h3F, 6'h3F, 6'h3F};
    vecs[1]  = '{16'hFFFE, 6'h3E, 6'h3F, 6'h3E, 6'h3F};
    vecs[2]  = '{16'hDFFF, 6'h3F, 6'h1F, 6'h3E, 6'h3F};
    vecs[3]  = '{16'hDFFF, 6'h3F, 6'h1F, 6'h3F, 6'h1F};
    vecs[4]  = '{16'h1F3F, 6'h3F, 6'h1F, 6'h3F, 6'h1F};
    vecs[5]  = '{16'hFFFF, 6'h3F, 6'h3F, 6'h3F, 6'h1F};
    vecs[6]  = '{16'hFFFF, 6'h3F, 6'h3F, 6'h3F, 6'h3F};
    vecs[7]  = '{16'hFFFE, 6'h3E, 6'h3F, 6'h3F, 6'h3F};
    vecs[8]  = '{16'hFFFF, 6'h3F, 6'h3F, 6'h3F, 6'h3F};
    vecs[9]  = '{16'h2A15, 6'h15, 6'h2A, 6'h3F, 6'h3F};
    vecs[10] = '{16'h2A15, 6'h15, 6'h2A, 6'h15, 6'h2A};
    vecs[11] = '{16'hC0C0, 6'h00, 6'h00, 6'h15, 6'h2A};

    // Reset held, then released with the PLL unlocked: pins parked and quiet.
    repeat (3) @(posedge clk);
    #1;
    chk_reset_values("in_reset");
    @(negedge clk) rst_n = 1'b1;
    viol = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (joy_load !== 1'b1 || joy_clk !== 1'b0 || joy1 !== 6'h3F || joy2 !== 6'h3F || frame_strobe !== 1'b0)
        viol++;
    end
    chk("idle_quiet_violations", 16'(viol), 16'h0);

    // First frame after lock.
    @(negedge clk) clock_locked = 1'b1;
    wait_strobe(400, n);
    chk("first_strobe_latency", 16'(n), 16'(LATENCY));
    chk("first_joy1", 16'(joy1), 16'h3F);
    chk("first_joy2", 16'(joy2), 16'h3F);
    last_cyc = cyc;
    @(posedge clk); #1;
    chk("first_strobe_width", 16'(frame_strobe), 16'h0);

    // One vector per frame; the new pattern is set during GAP so the next LOAD picks it up.
    for (int i = 0; i < 12; i++) begin
      pattern = vecs[i].pat;
      wait_strobe(400, n);
      chk($sformatf("v%0d_period", i), 16'(cyc - last_cyc), 16'(PERIOD));
      last_cyc = cyc;
      chk($sformatf("v%0d_joy1", i), 16'(joy1), 16'(pick(vecs[i].j1, vecs[i].j1_db)));
      chk($sformatf("v%0d_joy2", i), 16'(joy2), 16'(pick(vecs[i].j2, vecs[i].j2_db)));
      @(posedge clk); #1;
      chk($sformatf("v%0d_strobe_width", i), 16'(frame_strobe), 16'h0);
    end

    // Lock loss during SHIFT_HI at idx 7 of a frame that would otherwise change the outputs.
    pattern = 16'hFFFF;
    wait_edges(1'b1, 8);
    clock_locked = 1'b0;
    @(posedge clk); #1;
    chk("unlock_joy_clk", 16'(joy_clk), 16'h0);
    chk("unlock_joy_load", 16'(joy_load), 16'h1);
    viol = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (frame_strobe !== 1'b0 || joy_clk !== 1'b0 || joy_load !== 1'b1 ||
          joy1 !== pick(6'h00, 6'h15) || joy2 !== pick(6'h00, 6'h2A))
        viol++;
    end
    chk("unlock_hold_violations", 16'(viol), 16'h0);

    // Re-lock: a complete fresh frame follows.
    pattern = 16'hC0C0;
    @(negedge clk) clock_locked = 1'b1;
    wait_strobe(400, n);
    chk("relock_latency", 16'(n), 16'(LATENCY));
    chk("relock_joy1", 16'(joy1), 16'h00);
    chk("relock_joy2", 16'(joy2), 16'h00);

    // Asynchronous reset during SHIFT_LO at idx 10, checked before any clock edge.
    pattern = 16'hFEFD;
    wait_edges(1'b0, 10);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk_reset_values("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    wait_strobe(400, n);
    chk("post_reset_latency", 16'(n), 16'(LATENCY));
    chk("post_reset_joy1", 16'(joy1), 16'(pick(6'h3D, 6'h3F)));
    chk("post_reset_joy2", 16'(joy2), 16'(pick(6'h3E, 6'h3F)));
    last_cyc = cyc;
    wait_strobe(400, n);
    chk("post_reset_period", 16'(cyc - last_cyc), 16'(PERIOD));
    chk("post_reset2_joy1", 16'(joy1), 16'h3D);
    chk("post_reset2_joy2", 16'(joy2), 16'h3E);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
